// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: ALU op codes, op-class and operand-select encodings.
// Capture-time ALU op decode lives here so ID/EX and any future stage agree.
package rv32i_pkg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [1:0] OPC_R   = 2'd0;
   localparam logic [1:0] OPC_I   = 2'd1;
   localparam logic [1:0] OPC_ADD = 2'd2;
   localparam logic [1:0] OPC_RSV = 2'd3;

   localparam logic [1:0] SEL_A_RS1  = 2'd0;
   localparam logic [1:0] SEL_A_PC   = 2'd1;
   localparam logic [1:0] SEL_A_ZERO = 2'd2;

   localparam logic [1:0] SEL_B_RS2  = 2'd0;
   localparam logic [1:0] SEL_B_IMM  = 2'd1;
   localparam logic [1:0] SEL_B_FOUR = 2'd2;

   // I-arith has no SUBI: bit 30 only survives for the shift-right encoding (SRAI).
   function automatic logic [3:0] alu_op_dec(input logic [1:0] op_class,
                                             input logic [2:0] funct3,
                                             input logic       funct7b5);
      case (op_class)
         OPC_R:   return {funct7b5, funct3};
         OPC_I:   return {funct7b5 & (funct3 == 3'b101), funct3};
         default: return ALU_ADD;
      endcase
   endfunction
endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding: EX/MEM beats MEM/WB, x0 never forwarded.
// Forwarding exists only when ID_EX_FORWARD_EN is defined; otherwise the register value passes through.
module fwd_mux #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] i_src,
   input  logic [XLEN-1:0] i_reg_data,
   input  logic [RA_W-1:0] i_exmem_rd,
   input  logic            i_exmem_we,
   input  logic [XLEN-1:0] i_exmem_result,
   input  logic [RA_W-1:0] i_memwb_rd,
   input  logic            i_memwb_we,
   input  logic [XLEN-1:0] i_memwb_result,
   output logic [XLEN-1:0] o_data,
   output logic            o_hit
);
`ifdef ID_EX_FORWARD_EN
   logic w_exmem_hit;
   logic w_memwb_hit;

   assign w_exmem_hit = i_exmem_we && (i_exmem_rd == i_src) && (i_src != '0);
   assign w_memwb_hit = i_memwb_we && (i_memwb_rd == i_src) && (i_src != '0);
   assign o_hit       = w_exmem_hit || w_memwb_hit;

   always_comb begin
      o_data = i_reg_data;
      if (w_exmem_hit)      o_data = i_exmem_result;
      else if (w_memwb_hit) o_data = i_memwb_result;
   end
`else
   logic w_unused;

   assign w_unused = ^{i_src, i_exmem_rd, i_exmem_we, i_exmem_result,
                       i_memwb_rd, i_memwb_we, i_memwb_result};
   assign o_data   = i_reg_data;
   assign o_hit    = 1'b0;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards rs1/rs2, selects ALU operands.
// Build option ID_EX_FORWARD_EN enables forwarding and stall-time refresh of held operands.
module id_ex_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN = rv32i_pkg::XLEN,
   parameter int RA_W = rv32i_pkg::RA_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  logic [XLEN-1:0] i_pc,
   input  logic [RA_W-1:0] i_rs1_addr,
   input  logic [RA_W-1:0] i_rs2_addr,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [XLEN-1:0] i_imm,
   input  logic [RA_W-1:0] i_rd_addr,
   input  logic            i_reg_write,
   input  logic [2:0]      i_funct3,
   input  logic            i_funct7b5,
   input  logic [1:0]      i_op_class,
   input  logic [1:0]      i_sel_a,
   input  logic [1:0]      i_sel_b,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic [RA_W-1:0] i_exmem_rd,
   input  logic            i_exmem_we,
   input  logic [XLEN-1:0] i_exmem_result,
   input  logic [RA_W-1:0] i_memwb_rd,
   input  logic            i_memwb_we,
   input  logic [XLEN-1:0] i_memwb_result,
   output logic            o_valid,
   output logic [XLEN-1:0] o_alu_input_a,
   output logic [XLEN-1:0] o_alu_input_b,
   output logic [3:0]      o_alu_op,
   output logic [XLEN-1:0] o_store_data,
   output logic [XLEN-1:0] o_pc,
   output logic [RA_W-1:0] o_rd_addr,
   output logic            o_reg_write
);
   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [RA_W-1:0] r_rs1_addr;
   logic [RA_W-1:0] r_rs2_addr;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic [RA_W-1:0] r_rd_addr;
   logic            r_reg_write;
   logic [3:0]      r_alu_op;
   logic [1:0]      r_sel_a;
   logic [1:0]      r_sel_b;

   logic [XLEN-1:0] w_rs1_fwd;
   logic [XLEN-1:0] w_rs2_fwd;
   logic            w_rs1_hit;
   logic            w_rs2_hit;

   fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .i_src(r_rs1_addr), .i_reg_data(r_rs1_data),
      .i_exmem_rd(i_exmem_rd), .i_exmem_we(i_exmem_we), .i_exmem_result(i_exmem_result),
      .i_memwb_rd(i_memwb_rd), .i_memwb_we(i_memwb_we), .i_memwb_result(i_memwb_result),
      .o_data(w_rs1_fwd), .o_hit(w_rs1_hit)
   );

   fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .i_src(r_rs2_addr), .i_reg_data(r_rs2_data),
      .i_exmem_rd(i_exmem_rd), .i_exmem_we(i_exmem_we), .i_exmem_result(i_exmem_result),
      .i_memwb_rd(i_memwb_rd), .i_memwb_we(i_memwb_we), .i_memwb_result(i_memwb_result),
      .o_data(w_rs2_fwd), .o_hit(w_rs2_hit)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_rd_addr   <= '0;
         r_reg_write <= 1'b0;
         r_alu_op    <= ALU_ADD;
         r_sel_a     <= SEL_A_RS1;
         r_sel_b     <= SEL_B_RS2;
      end else if (i_flush) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_alu_op    <= ALU_ADD;
      end else if (i_stall) begin
         // A producer may retire during a long stall; latch its value so it is not lost.
         if (w_rs1_hit) r_rs1_data <= w_rs1_fwd;
         if (w_rs2_hit) r_rs2_data <= w_rs2_fwd;
      end else begin
         r_valid     <= i_valid;
         r_pc        <= i_pc;
         r_rs1_addr  <= i_rs1_addr;
         r_rs2_addr  <= i_rs2_addr;
         r_rs1_data  <= i_rs1_data;
         r_rs2_data  <= i_rs2_data;
         r_imm       <= i_imm;
         r_rd_addr   <= i_rd_addr;
         r_reg_write <= i_reg_write;
         r_alu_op    <= alu_op_dec(i_op_class, i_funct3, i_funct7b5);
         r_sel_a     <= i_sel_a;
         r_sel_b     <= i_sel_b;
      end
   end

   always_comb begin
      case (r_sel_a)
         SEL_A_RS1: o_alu_input_a = w_rs1_fwd;
         SEL_A_PC:  o_alu_input_a = r_pc;
         default:   o_alu_input_a = '0;
      endcase
      case (r_sel_b)
         SEL_B_RS2:  o_alu_input_b = w_rs2_fwd;
         SEL_B_FOUR: o_alu_input_b = XLEN'(4);
         default:    o_alu_input_b = r_imm;
      endcase
   end

   assign o_valid      = r_valid;
   assign o_alu_op     = r_alu_op;
   assign o_store_data = w_rs2_fwd;
   assign o_pc         = r_pc;
   assign o_rd_addr    = r_rd_addr;
   assign o_reg_write  = r_reg_write & r_valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/select vector table plus forwarding, stall, flush, reset sequences.
// Forwarding expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [31:0] i_pc;
   logic [4:0]  i_rs1_addr, i_rs2_addr;
   logic [31:0] i_rs1_data, i_rs2_data, i_imm;
   logic [4:0]  i_rd_addr;
   logic        i_reg_write;
   logic [2:0]  i_funct3;
   logic        i_funct7b5;
   logic [1:0]  i_op_class, i_sel_a, i_sel_b;
   logic        i_stall, i_flush;
   logic [4:0]  i_exmem_rd, i_memwb_rd;
   logic        i_exmem_we, i_memwb_we;
   logic [31:0] i_exmem_result, i_memwb_result;
   logic        o_valid;
   logic [31:0] o_alu_input_a, o_alu_input_b, o_store_data, o_pc;
   logic [3:0]  o_alu_op;
   logic [4:0]  o_rd_addr;
   logic        o_reg_write;

   always #5 i_clk = ~i_clk;

   id_ex_stage dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
      .i_rd_addr(i_rd_addr), .i_reg_write(i_reg_write), .i_funct3(i_funct3),
      .i_funct7b5(i_funct7b5), .i_op_class(i_op_class), .i_sel_a(i_sel_a),
      .i_sel_b(i_sel_b), .i_stall(i_stall), .i_flush(i_flush),
      .i_exmem_rd(i_exmem_rd), .i_exmem_we(i_exmem_we), .i_exmem_result(i_exmem_result),
      .i_memwb_rd(i_memwb_rd), .i_memwb_we(i_memwb_we), .i_memwb_result(i_memwb_result),
      .o_valid(o_valid), .o_alu_input_a(o_alu_input_a), .o_alu_input_b(o_alu_input_b),
      .o_alu_op(o_alu_op), .o_store_data(o_store_data), .o_pc(o_pc),
      .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1a, rs2a;
      logic [31:0] rs1d, rs2d, imm;
      logic [4:0]  rd;
      logic        we;
      logic [2:0]  f3;
      logic        f7;
      logic [1:0]  opc, sa, sb;
      logic [3:0]  e_op;
      logic [31:0] e_a, e_b;
      logic        e_v, e_rw;
   } vec_t;

   vec_t tv[12];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs1a, logic [4:0] rs2a,
                               logic [31:0] rs1d, logic [31:0] rs2d, logic [31:0] imm,
                               logic [4:0] rd, logic we, logic [2:0] f3, logic f7,
                               logic [1:0] opc, logic [1:0] sa, logic [1:0] sb,
                               logic [3:0] e_op, logic [31:0] e_a, logic [31:0] e_b,
                               logic e_v, logic e_rw);
      vec_t t;
      t.valid = v; t.pc = pc; t.rs1a = rs1a; t.rs2a = rs2a; t.rs1d = rs1d; t.rs2d = rs2d;
      t.imm = imm; t.rd = rd; t.we = we; t.f3 = f3; t.f7 = f7; t.opc = opc; t.sa = sa;
      t.sb = sb; t.e_op = e_op; t.e_a = e_a; t.e_b = e_b; t.e_v = e_v; t.e_rw = e_rw;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      i_valid = t.valid; i_pc = t.pc; i_rs1_addr = t.rs1a; i_rs2_addr = t.rs2a;
      i_rs1_data = t.rs1d; i_rs2_data = t.rs2d; i_imm = t.imm; i_rd_addr = t.rd;
      i_reg_write = t.we; i_funct3 = t.f3; i_funct7b5 = t.f7; i_op_class = t.opc;
      i_sel_a = t.sa; i_sel_b = t.sb;
   endtask

   task automatic clr_fwd();
      i_exmem_rd = 5'd0; i_exmem_we = 1'b0; i_exmem_result = 32'h0;
      i_memwb_rd = 5'd0; i_memwb_we = 1'b0; i_memwb_result = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //           v  pc      rs1 rs2 rs1d          rs2d          imm           rd we f3 f7 opc sa sb | op    a             b             v rw
      tv[0]  = mk(1, 32'h10,  1,  2,  32'haaaa007f, 32'h5555001c, 32'h0,        3, 1, 0, 1, 0, 0, 0, 4'h8, 32'haaaa007f, 32'h5555001c, 1, 1);
      tv[1]  = mk(1, 32'h14,  1,  0,  32'h80000000, 32'h0,        32'h40c,      4, 1, 5, 1, 1, 0, 1, 4'hd, 32'h80000000, 32'h0000040c, 1, 1);
      tv[2]  = mk(1, 32'h18,  1,  0,  32'h10,       32'h0,        32'hfffffff0, 5, 1, 0, 1, 1, 0, 1, 4'h0, 32'h10,       32'hfffffff0, 1, 1);
      tv[3]  = mk(1, 32'h1c,  6,  7,  32'h1,        32'h2,        32'h0,        8, 1, 3, 0, 0, 0, 0, 4'h3, 32'h1,        32'h2,        1, 1);
      tv[4]  = mk(1, 32'h20,  6,  7,  32'hf0000000, 32'h4,        32'h0,        9, 1, 5, 1, 0, 0, 0, 4'hd, 32'hf0000000, 32'h4,        1, 1);
      tv[5]  = mk(1, 32'h24,  6,  0,  32'h3,        32'h0,        32'h2,       10, 1, 1, 1, 1, 0, 1, 4'h1, 32'h3,        32'h2,        1, 1);
      tv[6]  = mk(1, 32'h28,  6,  7,  32'h5,        32'h6,        32'h0,       11, 1, 5, 1, 3, 0, 0, 4'h0, 32'h5,        32'h6,        1, 1);
      tv[7]  = mk(1, 32'h100, 0,  0,  32'h0,        32'h0,        32'h800,      1, 1, 0, 0, 2, 1, 2, 4'h0, 32'h100,      32'h4,        1, 1);
      tv[8]  = mk(1, 32'h30,  1,  2,  32'h12345678, 32'h9abcdef0, 32'h55,      12, 1, 4, 0, 0, 2, 3, 4'h4, 32'h0,        32'h55,       1, 1);
      tv[9]  = mk(0, 32'h34,  1,  2,  32'h11,       32'h22,       32'h0,       13, 1, 6, 0, 0, 3, 0, 4'h6, 32'h0,        32'h22,       0, 0);
      tv[10] = mk(1, 32'h38,  1,  2,  32'h11,       32'h22,       32'h0,       14, 0, 7, 0, 0, 0, 0, 4'h7, 32'h11,       32'h22,       1, 0);
      tv[11] = mk(1, 32'h3c,  1,  2,  32'hff,       32'h1,        32'h0,       15, 1, 5, 0, 0, 0, 0, 4'h5, 32'hff,       32'h1,        1, 1);

      i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      clr_fwd();
      #2;
      check("rst_valid", o_valid, 0);
      check("rst_reg_write", o_reg_write, 0);
      check("rst_alu_op", o_alu_op, 0);
      check("rst_pc", o_pc, 0);
      check("rst_rd", o_rd_addr, 0);
      check("rst_a", o_alu_input_a, 0);
      check("rst_b", o_alu_input_b, 0);
      check("rst_store", o_store_data, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge i_clk);
         drive(tv[i]);
         @(posedge i_clk);
         #1;
         check($sformatf("v%0d_op", i), o_alu_op, tv[i].e_op);
         check($sformatf("v%0d_a", i), o_alu_input_a, tv[i].e_a);
         check($sformatf("v%0d_b", i), o_alu_input_b, tv[i].e_b);
         check($sformatf("v%0d_valid", i), o_valid, tv[i].e_v);
         check($sformatf("v%0d_rw", i), o_reg_write, tv[i].e_rw);
         check($sformatf("v%0d_pc", i), o_pc, tv[i].pc);
         check($sformatf("v%0d_rd", i), o_rd_addr, tv[i].rd);
         check($sformatf("v%0d_store", i), o_store_data, tv[i].rs2d);
      end

      // forwarding priority on rs1 and rs2 = x5
      @(negedge i_clk);
      drive(mk(1, 32'h40, 5, 5, 32'h55, 32'h66, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge i_clk);
      #1;
      check("fwd_none_a", o_alu_input_a, 32'h55);
      i_exmem_rd = 5; i_exmem_we = 1; i_exmem_result = 32'h11111111;
      i_memwb_rd = 5; i_memwb_we = 1; i_memwb_result = 32'h22222222;
      #1;
      check("fwd_both_a", o_alu_input_a, FWD ? 32'h11111111 : 32'h55);
      check("fwd_both_store", o_store_data, FWD ? 32'h11111111 : 32'h66);
      i_exmem_we = 0;
      #1;
      check("fwd_memwb_a", o_alu_input_a, FWD ? 32'h22222222 : 32'h55);
      check("fwd_memwb_b", o_alu_input_b, FWD ? 32'h22222222 : 32'h66);
      @(negedge i_clk);
      drive(mk(1, 32'h44, 0, 0, 32'h77, 32'h88, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      i_exmem_rd = 0; i_exmem_we = 1; i_memwb_rd = 0; i_memwb_we = 1;
      @(posedge i_clk);
      #1;
      check("fwd_x0_a", o_alu_input_a, 32'h77);
      check("fwd_x0_b", o_alu_input_b, 32'h88);
      clr_fwd();

      // stall refresh: MEM/WB result for x3 present only in the first stall cycle
      @(negedge i_clk);
      drive(mk(1, 32'h200, 3, 0, 32'h1234, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge i_clk);
      #1;
      check("stall_pre_a", o_alu_input_a, 32'h1234);
      for (int c = 1; c <= 3; c++) begin
         @(negedge i_clk);
         i_stall = 1'b1;
         i_pc = 32'h999; i_rs1_data = 32'haaaa;
         i_memwb_rd = 3; i_memwb_we = (c == 1); i_memwb_result = 32'hdeadbeef;
         #1;
         check($sformatf("stall_c%0d_a", c), o_alu_input_a, FWD ? 32'hdeadbeef : 32'h1234);
         @(posedge i_clk);
         #1;
         check($sformatf("stall_c%0d_pc", c), o_pc, 32'h200);
         check($sformatf("stall_c%0d_valid", c), o_valid, 1);
      end
      @(negedge i_clk);
      i_stall = 1'b0; i_memwb_we = 1'b0;
      #1;
      check("stall_rel_a", o_alu_input_a, FWD ? 32'hdeadbeef : 32'h1234);
      @(posedge i_clk);
      #1;
      check("stall_load_pc", o_pc, 32'h999);
      check("stall_load_a", o_alu_input_a, 32'haaaa);
      clr_fwd();

      // simultaneous stall and flush produces a bubble
      @(negedge i_clk);
      drive(tv[0]);
      @(posedge i_clk);
      #1;
      check("sf_pre_op", o_alu_op, 4'h8);
      @(negedge i_clk);
      i_stall = 1'b1; i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      check("sf_valid", o_valid, 0);
      check("sf_rw", o_reg_write, 0);
      check("sf_op", o_alu_op, 0);
      @(negedge i_clk);
      i_stall = 1'b0; i_flush = 1'b0;

      // JAL operands, then asynchronous reset between edges
      drive(tv[7]);
      @(posedge i_clk);
      #1;
      check("jal_a", o_alu_input_a, 32'h100);
      check("jal_b", o_alu_input_b, 32'h4);
      check("jal_op", o_alu_op, 0);
      check("jal_valid", o_valid, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_rw", o_reg_write, 0);
      check("arst_a", o_alu_input_a, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) of the rv32i core.
- Registers the decoded instruction fields and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Selects and drives the ALU operands and the 4-bit ALU op code.
- Supports a stall (hold) and a flush (bubble) from the hazard/branch control.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  ID holds a valid instruction.
- i_pc  in  XLEN  PC of the ID instruction.
- i_rs1_addr, i_rs2_addr  in  RA_W  source register indices.
- i_rs1_data, i_rs2_data  in  XLEN  register-file read data.
- i_imm  in  XLEN  sign-extended immediate.
- i_rd_addr  in  RA_W  destination register index.
- i_reg_write  in  1  instruction writes rd.
- i_funct3  in  3  instruction funct3.
- i_funct7b5  in  1  instruction bit 30.
- i_op_class  in  2  0=R-type, 1=I-arith, 2=force-ADD (load/store/lui/auipc/jal/jalr), 3=reserved (treated as 2).
- i_sel_a  in  2  operand A source: 0=rs1, 1=pc, 2=zero, 3=zero.
- i_sel_b  in  2  operand B source: 0=rs2, 1=imm, 2=constant 4, 3=imm.
- i_stall  in  1  hold stage contents.
- i_flush  in  1  replace captured instruction with a bubble.
- i_exmem_rd  in  RA_W  EX/MEM destination register.
- i_exmem_we  in  1  EX/MEM writes rd.
- i_exmem_result  in  XLEN  EX/MEM ALU result.
- i_memwb_rd  in  RA_W  MEM/WB destination register.
- i_memwb_we  in  1  MEM/WB writes rd.
- i_memwb_result  in  XLEN  MEM/WB writeback value.
- o_valid  out  1  EX holds a valid instruction.
- o_alu_input_a, o_alu_input_b  out  XLEN  ALU operands.
- o_alu_op  out  4  ALU op code.
- o_store_data  out  XLEN  forwarded rs2 value, for stores and branches.
- o_pc  out  XLEN  registered PC.
- o_rd_addr  out  RA_W  registered rd.
- o_reg_write  out  1  registered write enable, gated by o_valid.

Behaviour:
- Reset (async, i_rst_n=0): every registered field is 0, so o_valid=0, o_reg_write=0, o_alu_op=0000 (ADD), o_pc=0, o_rd_addr=0. Combinational outputs resolve to 0.
- Latency: 1 cycle from ID inputs to registered fields. Operand outputs are combinational from registered fields plus the forwarding inputs in the same cycle.
- Update priority at each edge: flush > stall > load.
  - Flush: valid=0, reg_write=0, alu_op=0000; other fields don't-care. Flush wins over a simultaneous stall.
  - Stall: all fields hold, except that held rs1/rs2 data are overwritten with their forwarded values whenever a forward hit occurs. This prevents a MEM/WB value from being lost during a multi-cycle stall.
  - Load: capture all inputs.
- ALU op encoding:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
  - R-type: {funct7b5, funct3}.
  - I-arith: {funct7b5 & (funct3==101), funct3}. There is no SUBI; only SRAI sets bit 3.
  - Force-ADD: 0000.
  - Computed at capture time and stored registered.
- Forwarding, per source s in {rs1, rs2}:
  - EX/MEM hit: exmem_we && exmem_rd==s && s!=0.
  - MEM/WB hit: memwb_we && memwb_rd==s && s!=0.
  - When both hit, EX/MEM wins.
  - Register x0 is never forwarded.
- Operand select applies after forwarding; constant 4 is 32'h00000004.
- Bubble outputs: operands still driven; downstream must ignore them because o_valid=0 and o_reg_write=0.
- Reset mid-stall or mid-flush: asynchronous reset dominates immediately.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding and stall-refresh exactly as above.
- Undefined:
  - Forwarding inputs are ignored and operands come only from registered rs data.
  - Stall holds data unchanged.
  - The hazard unit must stall until writeback completes.

Decomposition:
- Shared package `rv32i_pkg` holds:
  - ALU op localparams (ALU_ADD..ALU_SRA).
  - op_class and sel_a/sel_b encodings.
  - XLEN default.
- One natural sub-module, `fwd_mux`: per-operand comparator and priority mux, instantiated twice.

Test Plan:
- Reset then R-type SUB: rs1=x1=32'haaaa007f, rs2=x2=32'h5555001c, funct7b5=1, funct3=000 -> next cycle o_alu_op=1000, operands equal those inputs, o_valid=1.
- I-arith SRAI funct7b5=1 funct3=101 imm=32'h40c -> o_alu_op=1101, o_alu_input_b=32'h0000040c. I-arith ADDI with funct7b5=1 -> o_alu_op=0000.
- Forward priority: rs1=x5, EX/MEM rd=5 result=32'h11111111, MEM/WB rd=5 result=32'h22222222 -> o_alu_input_a=32'h11111111. Set exmem_we=0 -> 32'h22222222. Use rs1=x0 with both hitting rd=0 -> operand equals registered data.
- Stall refresh: stall 3 cycles with MEM/WB rd=3 result=32'hdeadbeef present only in cycle 1 -> operand remains 32'hdeadbeef through cycles 2-3 and the cycle after release.
- Simultaneous i_stall=1, i_flush=1 -> next cycle o_valid=0, o_reg_write=0, o_alu_op=0000.
- JAL-style: sel_a=pc, sel_b=4, op_class=2, pc=32'h00000100 -> operands 32'h00000100 and 32'h00000004, o_alu_op=0000. Assert i_rst_n=0 mid-cycle -> o_valid drops to 0 without waiting for a clock edge.
